// File: rtl/mips_io_defs.sv
// Shared definitions for the memory-mapped MIPS I/O port.
// Holds the default register addresses, the status-word bit positions and
// the output handshake FSM state encoding used by mips_io_port.
package mips_io_defs;

  // Default addresses of the three mapped registers.
  localparam logic [31:0] OUT_ADDR_DEF  = 32'h1001_0024;
  localparam logic [31:0] IN_ADDR_DEF   = 32'h1001_0028;
  localparam logic [31:0] STAT_ADDR_DEF = 32'h1001_002C;

  // Bit positions inside the status word {28'b0, write_drop, overrun, in_full, out_busy}.
  localparam int STAT_OUT_BUSY   = 0;
  localparam int STAT_IN_FULL    = 1;
  localparam int STAT_OVERRUN    = 2;
  localparam int STAT_WRITE_DROP = 3;

  // Output-side four-phase handshake states.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEND    = 2'd1,
    RELEASE = 2'd2
  } out_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous control bit.
// Ports:
//   clk   - destination clock
//   reset - synchronous active-high reset, clears both flops
//   d     - asynchronous input
//   q     - input resampled into the clk domain (two-cycle latency)
module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  // NOTE: sequential state uses non-blocking assignments so meta and q both
  // sample their pre-edge values; blocking here would collapse the two stages.
  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/mips_io_port.sv
// Memory-mapped I/O port for a MIPS-style data bus.
// An output register is offered to an external device with a four-phase
// valid/ack handshake; an input byte is captured on the device's valid
// request. A status register reports busy/full/overrun/drop conditions.
// Ports:
//   clk, reset         - single clock, synchronous active-high reset
//   MemWrite, MemRead  - processor store / load strobes
//   Address, WriteData - processor data address and store data
//   ReadData           - combinational load data
//   PortOut, out_valid - output word and its valid flag to the device
//   out_ack            - asynchronous device acknowledge for PortOut
//   PortIn, in_valid   - input byte and asynchronous capture request
//   in_ack             - one-cycle pulse when PortIn has been captured
module mips_io_port
  import mips_io_defs::*;
#(
  parameter logic [31:0] OUT_ADDR  = OUT_ADDR_DEF,
  parameter logic [31:0] IN_ADDR   = IN_ADDR_DEF,
  parameter logic [31:0] STAT_ADDR = STAT_ADDR_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic        MemRead,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic [31:0] PortOut,
  output logic        out_valid,
  input  logic        out_ack,
  input  logic [7:0]  PortIn,
  input  logic        in_valid,
  output logic        in_ack
);

  out_state_t  state;
  out_state_t  state_next;

  logic        in_valid_s;
  logic        in_valid_d;
  logic        out_ack_s;
  logic [31:0] in_reg;
  logic        in_full;
  logic        overrun;
  logic        write_drop;
  logic        out_busy;

  logic        wr_out;
  logic        rd_in;
  logic        rd_stat;
  logic        in_rise;
  logic        capture;
  logic        overrun_set;
  logic        drop_set;

  sync_2ff u_sync_in_valid (
    .clk   (clk),
    .reset (reset),
    .d     (in_valid),
    .q     (in_valid_s)
  );

  sync_2ff u_sync_out_ack (
    .clk   (clk),
    .reset (reset),
    .d     (out_ack),
    .q     (out_ack_s)
  );

  // Bus decode.
  assign wr_out  = MemWrite && (Address == OUT_ADDR);
  assign rd_in   = MemRead  && (Address == IN_ADDR);
  assign rd_stat = MemRead  && (Address == STAT_ADDR);

  // Edge detect on the synchronized request: the capture edge is the third
  // clk edge after in_valid rises (two synchronizer stages, then this edge).
  assign in_rise     = in_valid_s && !in_valid_d;
  assign capture     = in_rise && !in_full;
  assign overrun_set = in_rise && in_full;
  assign drop_set    = wr_out && (state != IDLE);
  assign out_busy    = (state != IDLE);

  // Output handshake FSM: next state and out_valid.
  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement leaves it unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    out_valid  = 1'b0;
    unique case (state)
      IDLE: begin
        if (wr_out) state_next = SEND;
      end
      SEND: begin
        out_valid = 1'b1;
        if (out_ack_s) state_next = RELEASE;
      end
      RELEASE: begin
        if (!out_ack_s) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      PortOut    <= '0;
      in_valid_d <= 1'b0;
      in_reg     <= '0;
      in_full    <= 1'b0;
      in_ack     <= 1'b0;
      overrun    <= 1'b0;
      write_drop <= 1'b0;
    end else begin
      state      <= state_next;
      in_valid_d <= in_valid_s;
      in_ack     <= capture;

      // Only an idle port accepts a new output word; later writes are dropped.
      if (wr_out && (state == IDLE)) PortOut <= WriteData;

      if (capture) in_reg <= {24'b0, PortIn};

      // Set events take priority over the read-to-clear on the same edge.
      if (capture)    in_full <= 1'b1;
      else if (rd_in) in_full <= 1'b0;

      if (overrun_set)  overrun <= 1'b1;
      else if (rd_stat) overrun <= 1'b0;

      if (drop_set)     write_drop <= 1'b1;
      else if (rd_stat) write_drop <= 1'b0;
    end
  end

  // Combinational load path; unmapped addresses and idle bus read as zero.
  always_comb begin
    ReadData = '0;
    if (MemRead) begin
      if (Address == IN_ADDR) begin
        ReadData = in_reg;
      end else if (Address == OUT_ADDR) begin
        ReadData = PortOut;
      end else if (Address == STAT_ADDR) begin
        ReadData[STAT_OUT_BUSY]   = out_busy;
        ReadData[STAT_IN_FULL]    = in_full;
        ReadData[STAT_OVERRUN]    = overrun;
        ReadData[STAT_WRITE_DROP] = write_drop;
      end
    end
  end

endmodule

// File: tb/tb_mips_io_port.sv
// Directed self-checking bench for mips_io_port.
module tb_mips_io_port;

  localparam logic [31:0] OUT_A  = 32'h1001_0024;
  localparam logic [31:0] IN_A   = 32'h1001_0028;
  localparam logic [31:0] STAT_A = 32'h1001_002C;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemWrite;
  logic        MemRead;
  logic [31:0] Address;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic [31:0] PortOut;
  logic        out_valid;
  logic        out_ack;
  logic [7:0]  PortIn;
  logic        in_valid;
  logic        in_ack;

  int checks   = 0;
  int failures = 0;

  mips_io_port dut (
    .clk       (clk),
    .reset     (reset),
    .MemWrite  (MemWrite),
    .MemRead   (MemRead),
    .Address   (Address),
    .WriteData (WriteData),
    .ReadData  (ReadData),
    .PortOut   (PortOut),
    .out_valid (out_valid),
    .out_ack   (out_ack),
    .PortIn    (PortIn),
    .in_valid  (in_valid),
    .in_ack    (in_ack)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_write(input logic [31:0] addr, input logic [31:0] data);
    MemWrite  = 1'b1;
    Address   = addr;
    WriteData = data;
    tick();
    MemWrite  = 1'b0;
    Address   = '0;
    WriteData = '0;
  endtask

  // Check the combinational load value, then let the read take effect at the edge.
  task automatic cpu_read(input logic [31:0] addr, input logic [31:0] exp, input string tag);
    MemRead = 1'b1;
    Address = addr;
    #1;
    check(tag, ReadData, exp);
    tick();
    MemRead = 1'b0;
    Address = '0;
  endtask

  task automatic in_pulse(input logic [7:0] val);
    PortIn   = val;
    in_valid = 1'b1;
    repeat (3) tick();
    in_valid = 1'b0;
    repeat (3) tick();
  endtask

  // Full four-phase completion with bounded waits.
  task automatic finish_handshake(input string tag);
    out_ack = 1'b1;
    for (int n = 0; n < 3 && out_valid; n++) tick();
    check({tag, "_valid_low"}, {31'b0, out_valid}, 32'h0);
    out_ack = 1'b0;
    MemRead = 1'b1;
    Address = STAT_A;
    #1;
    for (int n = 0; n < 3 && ReadData[0]; n++) tick();
    check({tag, "_busy_clear"}, {31'b0, ReadData[0]}, 32'h0);
    MemRead = 1'b0;
    Address = '0;
  endtask

  initial begin
    reset = 1'b1; MemWrite = 1'b0; MemRead = 1'b0; Address = '0; WriteData = '0;
    out_ack = 1'b0; PortIn = '0; in_valid = 1'b0;
    repeat (3) tick();
    reset = 1'b0;

    // Reset state
    check("rst_portout", PortOut, 32'h0);
    check("rst_out_valid", {31'b0, out_valid}, 32'h0);
    check("rst_in_ack", {31'b0, in_ack}, 32'h0);
    cpu_read(STAT_A, 32'h0, "rst_stat");
    cpu_read(IN_A, 32'h0, "rst_in_reg");

    // Store to OUT_ADDR and complete the handshake
    cpu_write(OUT_A, 32'hDEAD_BEEF);
    check("out_portout", PortOut, 32'hDEAD_BEEF);
    check("out_valid_hi", {31'b0, out_valid}, 32'h1);
    cpu_read(OUT_A, 32'hDEAD_BEEF, "out_readback");
    cpu_read(STAT_A, 32'h1, "out_stat_busy");
    cpu_read(32'h1001_0000, 32'h0, "unmapped_read");
    finish_handshake("hs1");

    // Writes to non-output addresses have no effect
    cpu_write(IN_A, 32'hFF);
    cpu_write(STAT_A, 32'hF);
    cpu_write(32'h1001_0030, 32'h1234);
    check("nowrite_portout", PortOut, 32'hDEAD_BEEF);
    cpu_read(IN_A, 32'h0, "nowrite_in");
    cpu_read(STAT_A, 32'h0, "nowrite_stat");

    // Back-to-back stores: second is dropped
    cpu_write(OUT_A, 32'h1);
    cpu_write(OUT_A, 32'h2);
    check("drop_portout", PortOut, 32'h1);
    cpu_read(STAT_A, 32'h9, "drop_stat");
    cpu_read(STAT_A, 32'h1, "drop_stat_clr");
    finish_handshake("hs2");

    // Single input capture: in_ack on the 3rd edge
    PortIn   = 8'h03;
    in_valid = 1'b1;
    repeat (2) tick();
    check("in_ack_early", {31'b0, in_ack}, 32'h0);
    tick();
    check("in_ack_pulse", {31'b0, in_ack}, 32'h1);
    tick();
    check("in_ack_one_cycle", {31'b0, in_ack}, 32'h0);
    in_valid = 1'b0;
    repeat (3) tick();
    cpu_read(STAT_A, 32'h2, "in_stat_full");
    cpu_read(IN_A, 32'h3, "in_data");
    cpu_read(STAT_A, 32'h0, "in_stat_empty");

    // Overrun
    in_pulse(8'h05);
    in_pulse(8'h07);
    cpu_read(STAT_A, 32'h6, "ovr_stat");
    cpu_read(IN_A, 32'h5, "ovr_data");
    cpu_read(STAT_A, 32'h0, "ovr_stat_clr");

    // Read of IN_ADDR on the capture edge: capture wins
    PortIn   = 8'hA5;
    in_valid = 1'b1;
    repeat (2) tick();
    cpu_read(IN_A, 32'h5, "race_old_data");
    check("race_in_ack", {31'b0, in_ack}, 32'h1);
    cpu_read(STAT_A, 32'h2, "race_stat_full");
    cpu_read(IN_A, 32'hA5, "race_new_data");
    in_valid = 1'b0;
    repeat (3) tick();

    // Reset while in SEND, with a capture pending
    cpu_write(OUT_A, 32'h1234_5678);
    check("rst_mid_valid_pre", {31'b0, out_valid}, 32'h1);
    PortIn   = 8'h44;
    in_valid = 1'b1;
    tick();
    reset    = 1'b1;
    in_valid = 1'b0;
    tick();
    check("rst_mid_valid", {31'b0, out_valid}, 32'h0);
    check("rst_mid_portout", PortOut, 32'h0);
    reset = 1'b0;
    cpu_read(STAT_A, 32'h0, "rst_mid_stat");
    repeat (2) tick();
    check("rst_mid_no_ack", {31'b0, in_ack}, 32'h0);
    cpu_read(IN_A, 32'h0, "rst_mid_in_reg");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
